mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Pipeline-side sequencer that sits directly upstream of the cache/main-memory subsystem. It accepts one load or store per handshake from the CPU memory stage and holds address, data, funct3 and read/write strobes stable until the memory subsystem signals ready. It stalls the pipeline while the access is outstanding, then returns the read data (already extended by the memory subsystem) with a one-cycle response pulse. It also screens misaligned accesses and aborts accesses that exceed a timeout, flagging an error instead.

## Interface
- TIMEOUT_CYCLES, default 256: maximum cycles in WAIT before the access is aborted; 0 disables the timeout.
- CNT_W, default 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  1  pipeline presents an access this cycle.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, unshifted (byte lane placement happens downstream).
- req_funct3_i  in  3  RV32 load/store funct3.
- stall_o  out  1  pipeline must hold its memory-stage inputs.
- resp_valid_o  out  1  one-cycle pulse: access finished.
- resp_rdata_o  out  32  load result, valid with resp_valid_o; 0 for stores and errors.
- resp_err_o  out  1  valid with resp_valid_o; misaligned access or timeout.
- mem_addr_o  out  32  to memory subsystem address port.
- mem_wdata_o  out  32  to memory subsystem write data.
- mem_write_o  out  1  memory write strobe.
- mem_read_o  out  1  memory read strobe.
- mem_funct3_o  out  3  to memory subsystem funct3.
- mem_ready_i  in  1  memory subsystem finished the presented access.
- mem_rdata_i  in  32  extended read data, valid while mem_ready_i = 1.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: when req_valid_i = 1, latch addr/wdata/funct3/write into holding registers.
  - Aligned request: go to WAIT.
  - Misaligned request (funct3[1:0]=01 with addr[0]=1; funct3[1:0]=10 with addr[1:0]≠0; funct3[1:0]=11 is also misaligned/illegal): go to RESP with err=1 and no memory strobe ever asserted.
- WAIT: mem_read_o = !write and mem_write_o = write, both driven from the holding registers; all mem_* outputs are constant for the whole state.
  - On an edge with mem_ready_i = 1: capture mem_rdata_i (loads) or 0 (stores) into the response register, set err=0, go to RESP.
  - Otherwise increment the timeout counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with ready still low: set err=1, rdata=0, go to RESP.
  - mem_ready_i has priority over the timeout when both occur on the same edge.
- RESP: resp_valid_o = 1, strobes = 0, req_valid_i is ignored; unconditionally go to IDLE.
- stall_o = (IDLE && req_valid_i) || WAIT; it is 0 in RESP.
- The timeout counter clears on entry to WAIT.

## Timing
- Reset values: state IDLE, all mem_* = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0, stall_o = 0 (combinational from state and req_valid_i), counter = 0.
- Reset asserted mid-access drops mem_read_o/mem_write_o immediately. The pending access is discarded and no response is produced.
- Latency from request to response, with ready returned after N WAIT cycles: request edge, then N WAIT cycles (N ≥ 1), then 1 RESP cycle. The minimum is a response 2 cycles after the request edge.
- A misaligned request gets its response exactly 1 cycle after acceptance.
- Back-to-back requests are separated by RESP. Memory strobes are always low for at least one cycle between accesses.
- mem_ready_i is ignored outside WAIT.

## Structure
- Add to mem_pkg:
  - ctrl_state_t enum {IDLE, WAIT, RESP}.
  - mem_req_t packed struct {write, addr, wdata, funct3}, used for the holding register.
  - funct3 size constants (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10).
- Single module. The misalignment check is a local function in mem_pkg; no sub-module is warranted.

## Test plan
- Word load at 0x100, mem_ready_i high on the 3rd WAIT cycle with rdata 0xDEADBEEF: mem_read_o high for exactly 3 cycles, stall_o high 4 cycles, then resp_valid_o=1, resp_rdata_o=0xDEADBEEF, resp_err_o=0.
- Byte store 0xAB at 0x103, immediate ready: mem_write_o=1 for 1 cycle with mem_addr_o=0x103 and mem_wdata_o=0xAB; response rdata=0, err=0.
- Halfword load at 0x101: mem_read_o never rises; resp_valid_o and resp_err_o are both 1 one cycle after the request; stall_o high 1 cycle.
- TIMEOUT_CYCLES=4, mem_ready_i held low: the strobe drops after 4 WAIT cycles, followed by resp_err_o=1 and rdata=0. Repeat with ready rising on the 4th WAIT cycle: err=0.
- Back-to-back loads with req_valid_i held high: exactly one response per access, at least one strobe-low cycle between accesses, and no re-issue during RESP.
- rst_ni pulsed low during WAIT: mem_read_o goes to 0 before the next edge, no resp_valid_o appears, and the next request is processed normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-access path: controller states, the held request
// and the RV32 load/store size encodings with the alignment screen.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // funct3[1:0] == 2'b11 has no RV32 load/store meaning, so it is refused as well.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Pipeline-side sequencer in front of the cache/memory subsystem: holds one access
// stable until ready, stalls the pipe meanwhile, screens misalignment and times out.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  output logic [2:0]  mem_funct3_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  ctrl_state_t      state_q, state_d;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             req_bad;

  assign req_bad = is_misaligned(req_funct3_i[1:0], req_addr_i[1:0]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d.write  = req_write_i;
          req_d.addr   = req_addr_i;
          req_d.wdata  = req_wdata_i;
          req_d.funct3 = req_funct3_i;
          cnt_d        = '0;
          if (req_bad) begin
            // Refused without ever touching the memory strobes.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready_i) begin
          state_d = RESP;
          rdata_d = req_q.write ? 32'd0 : mem_rdata_i;
          err_d   = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset drops them at once.
  assign mem_read_o   = (state_q == WAIT) && !req_q.write;
  assign mem_write_o  = (state_q == WAIT) && req_q.write;
  assign mem_addr_o   = req_q.addr;
  assign mem_wdata_o  = req_q.wdata;
  assign mem_funct3_o = req_q.funct3;

  assign stall_o      = ((state_q == IDLE) && req_valid_i) || (state_q == WAIT);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed scenarios followed by randomized
// accesses, with expected responses predicted from the access rules.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [2:0]  mem_funct3_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
    .stall_o(stall_o), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_funct3_o(mem_funct3_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Natural alignment: an access of 2^k bytes must start on a 2^k boundary.
  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3[1:0] == 2'b11) return 1'b1;
    size = 1 << f3[1:0];
    return (a % 32'(size)) != 32'd0;
  endfunction

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (resp_valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: response with no access pending (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("resp_rdata", resp_rdata_o, e.rdata);
        check("resp_err", 32'(resp_err_o), 32'(e.err));
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic scramble_req(input bit hold);
    req_valid_i  = hold ? 1'b1 : 1'($urandom_range(0, 1));
    req_write_i  = 1'($urandom_range(0, 1));
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    req_funct3_i = 3'($urandom_range(0, 7));
  endtask

  // lat = WAIT cycle on which ready is returned; lat > TO never returns it.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input int lat, input logic [31:0] rd,
                           input bit hold);
    int   waits;
    bit   mis;
    exp_t e;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_write_i  = w;
    req_addr_i   = a;
    req_wdata_i  = wd;
    req_funct3_i = f3;
    mem_ready_i  = 1'($urandom_range(0, 1));
    mem_rdata_i  = $urandom;
    mis     = model_misaligned(f3, a);
    waits   = mis ? 0 : ((lat <= TO) ? lat : TO);
    e.err   = mis || (lat > TO);
    e.rdata = (e.err || w) ? 32'd0 : rd;
    e.cyc   = cyc + waits + 1;
    sbq.push_back(e);
    #1 check("stall_on_req", 32'(stall_o), 32'd1);
    for (int k = 1; k <= waits; k++) begin
      @(negedge clk_i);
      scramble_req(hold);
      mem_ready_i = (k == lat);
      mem_rdata_i = (k == lat) ? rd : $urandom;
      #1;
      check("wait_read", 32'(mem_read_o), 32'(!w));
      check("wait_write", 32'(mem_write_o), 32'(w));
      check("wait_addr", mem_addr_o, a);
      check("wait_wdata", mem_wdata_o, wd);
      check("wait_funct3", 32'(mem_funct3_o), 32'(f3));
      check("wait_stall", 32'(stall_o), 32'd1);
    end
    @(negedge clk_i);
    scramble_req(hold);
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    #1;
    check("resp_read_low", 32'(mem_read_o), 32'd0);
    check("resp_write_low", 32'(mem_write_o), 32'd0);
    check("resp_stall_low", 32'(stall_o), 32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    req_valid_i = 1'b0;
    mem_ready_i = 1'($urandom_range(0, 1));
    #1;
    check("idle_stall", 32'(stall_o), 32'd0);
    check("idle_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
  endtask

  initial begin
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_resp_rdata", resp_rdata_o, 32'd0);
    check("rst_resp_err", 32'(resp_err_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_mem_ctrl", 32'({mem_read_o, mem_write_o, mem_funct3_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    idle_cycle();
    do_access(1'b0, 32'h100, 32'h0, 3'b010, 3, 32'hDEADBEEF, 1'b0);
    idle_cycle();
    do_access(1'b1, 32'h103, 32'hAB, 3'b000, 1, 32'h1234_5678, 1'b0);
    idle_cycle();
    do_access(1'b0, 32'h101, 32'h0, 3'b001, 1, 32'h5555_AAAA, 1'b0);
    idle_cycle();
    do_access(1'b0, 32'h200, 32'h0, 3'b010, 99, 32'h0BAD_F00D, 1'b0);
    idle_cycle();
    do_access(1'b0, 32'h204, 32'h0, 3'b010, TO, 32'hCAFE_0004, 1'b0);
    do_access(1'b0, 32'h300, 32'h0, 3'b010, 1, 32'h1111_1111, 1'b1);
    do_access(1'b0, 32'h304, 32'h0, 3'b100, 2, 32'h2222_2222, 1'b1);
    do_access(1'b1, 32'h306, 32'h77, 3'b001, 1, 32'h3333_3333, 1'b1);

    // Reset in the middle of a WAIT: the load is dropped without a response.
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_write_i  = 1'b0;
    req_addr_i   = 32'h400;
    req_funct3_i = 3'b010;
    mem_ready_i  = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1 check("pre_rst_read", 32'(mem_read_o), 32'd1);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_drops_read", 32'(mem_read_o), 32'd0);
    check("rst_drops_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    #1 check("rst_no_resp", 32'(resp_valid_o), 32'd0);
    rst_ni = 1'b1;
    do_access(1'b0, 32'h408, 32'h0, 3'b010, 2, 32'h600D_0001, 1'b0);

    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_access(w, a, $urandom, f3, int'($urandom_range(1, TO + 2)), $urandom,
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (3) idle_cycle();
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
